// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - round-robin Wishbone B3 arbiter with cyc-tenure lock and bus watchdog
//
// Shares one memory slave port between N_MASTERS Wishbone masters.
// Once a master is granted, it keeps the grant until it drops cyc, so bursts
// are never split. An unanswered strobe held for TIMEOUT cycles is converted
// into a one-cycle error to the owner (TIMEOUT = 0 disables this).
//
// Ports:
//   wb_clk_i, wb_rst_ni        clock, asynchronous active-low reset
//   m_adr_i .. m_bte_i         packed master request buses, master k at slice k
//   m_dat_o                    slave read data, broadcast to every master
//   m_ack_o, m_err_o, m_rty_o  per-master responses, only the owner sees them
//   s_adr_o .. s_bte_o         request to the slave, muxed from the owner
//   s_dat_i, s_ack_i, s_err_i, s_rty_i  slave responses
//   grant_o                    registered one-hot grant, zero when idle
module wb_mem_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic [N_MASTERS*AW-1:0]  m_adr_i,
    input  logic [N_MASTERS*DW-1:0]  m_dat_i,
    input  logic [N_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [N_MASTERS-1:0]     m_we_i,
    input  logic [N_MASTERS-1:0]     m_cyc_i,
    input  logic [N_MASTERS-1:0]     m_stb_i,
    input  logic [N_MASTERS*3-1:0]   m_cti_i,
    input  logic [N_MASTERS*2-1:0]   m_bte_i,
    output logic [DW-1:0]            m_dat_o,
    output logic [N_MASTERS-1:0]     m_ack_o,
    output logic [N_MASTERS-1:0]     m_err_o,
    output logic [N_MASTERS-1:0]     m_rty_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    output logic [DW/8-1:0]          s_sel_o,
    output logic                     s_we_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic [2:0]               s_cti_o,
    output logic [1:0]               s_bte_o,
    input  logic [DW-1:0]            s_dat_i,
    input  logic                     s_ack_i,
    input  logic                     s_err_i,
    input  logic                     s_rty_i,
    output logic [N_MASTERS-1:0]     grant_o
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [WW-1:0] WD_MAX   = WD_EN ? WW'(TIMEOUT - 1) : '0;
    localparam logic [IW-1:0] LAST_RST = IW'(N_MASTERS - 1);

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t                state;
    logic [N_MASTERS-1:0]  grant;
    logic [IW-1:0]         last;     // current owner while OWNED, previous owner while IDLE
    logic [WW-1:0]         wdog;

    logic                  owned;
    logic                  active;
    logic                  slave_resp;
    logic                  wd_cond;
    logic                  wd_fire;
    logic [IW-1:0]         winner;
    logic                  found;
    logic [N_MASTERS-1:0]  win_onehot;

    assign owned      = (state == ST_OWNED);
    // The slave request follows the owner's cyc combinationally so a release
    // is visible to the slave in the same cycle.
    assign active     = owned & m_cyc_i[last];
    assign slave_resp = s_ack_i | s_err_i | s_rty_i;
    assign wd_cond    = active & m_stb_i[last] & ~slave_resp;
    assign wd_fire    = WD_EN & wd_cond & (wdog == WD_MAX);

    assign grant_o = grant;
    assign m_dat_o = s_dat_i;

    assign s_cyc_o = active;
    assign s_stb_o = active & m_stb_i[last] & ~wd_fire;
    assign s_adr_o = active ? m_adr_i[int'(last)*AW +: AW] : '0;
    assign s_dat_o = active ? m_dat_i[int'(last)*DW +: DW] : '0;
    assign s_sel_o = active ? m_sel_i[int'(last)*(DW/8) +: DW/8] : '0;
    assign s_we_o  = active & m_we_i[last];
    assign s_cti_o = active ? m_cti_i[int'(last)*3 +: 3] : 3'b000;
    assign s_bte_o = active ? m_bte_i[int'(last)*2 +: 2] : 2'b00;

    // Round-robin pick: first requester after the previous owner, wrapping.
    always_comb begin
        winner = last;
        found  = 1'b0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            if (!found && m_cyc_i[(int'(last) + i) % N_MASTERS]) begin
                found  = 1'b1;
                winner = IW'((int'(last) + i) % N_MASTERS);
            end
        end
    end

    always_comb begin
        win_onehot         = '0;
        win_onehot[winner] = 1'b1;
    end

    always_comb begin
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (owned && (last == IW'(k))) begin
                m_ack_o[k] = s_ack_i;
                m_err_o[k] = s_err_i | wd_fire;
                m_rty_o[k] = s_rty_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
            grant <= '0;
            last  <= LAST_RST;
            wdog  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (|m_cyc_i) begin
                        state <= ST_OWNED;
                        grant <= win_onehot;
                        last  <= winner;
                    end
                end
                ST_OWNED: begin
                    if (!m_cyc_i[last]) begin
                        state <= ST_IDLE;
                        grant <= '0;
                        wdog  <= '0;
                    end else if (wd_cond && !wd_fire) begin
                        wdog <= wdog + 1'b1;
                    end else begin
                        wdog <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - self-checking bench for wb_mem_arbiter
module tb_wb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst_n;

    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N*DW/8-1:0] m_sel;
    logic [N-1:0]      m_we, m_cyc, m_stb;
    logic [N*3-1:0]    m_cti;
    logic [N*2-1:0]    m_bte;
    logic [DW-1:0]     s_dat;
    logic              s_ack, s_err, s_rty;

    logic [DW-1:0]     m_dat_o, m_dat_o0;
    logic [N-1:0]      m_ack_o, m_err_o, m_rty_o, grant_o;
    logic [N-1:0]      m_ack_o0, m_err_o0, m_rty_o0, grant_o0;
    logic [AW-1:0]     s_adr_o, s_adr_o0;
    logic [DW-1:0]     s_dat_o, s_dat_o0;
    logic [DW/8-1:0]   s_sel_o, s_sel_o0;
    logic              s_we_o, s_cyc_o, s_stb_o, s_we_o0, s_cyc_o0, s_stb_o0;
    logic [2:0]        s_cti_o, s_cti_o0;
    logic [1:0]        s_bte_o, s_bte_o0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(T)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o)
    );

    wb_mem_arbiter #(.N_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(m_dat_o0), .m_ack_o(m_ack_o0), .m_err_o(m_err_o0), .m_rty_o(m_rty_o0),
        .s_adr_o(s_adr_o0), .s_dat_o(s_dat_o0), .s_sel_o(s_sel_o0), .s_we_o(s_we_o0),
        .s_cyc_o(s_cyc_o0), .s_stb_o(s_stb_o0), .s_cti_o(s_cti_o0), .s_bte_o(s_bte_o0),
        .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(grant_o0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus (-1 = nobody), who owned it last,
    // and how many unanswered strobed cycles the owner has accumulated.
    int mo_owner, mo_last, mo_cnt;

    function automatic int pick(input int l);
        for (int i = 1; i <= N; i++)
            if (m_cyc[(l + i) % N]) return (l + i) % N;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mo_owner <= -1;
            mo_last  <= N - 1;
            mo_cnt   <= 0;
        end else if (mo_owner < 0) begin
            if (m_cyc != '0) begin
                mo_owner <= pick(mo_last);
                mo_last  <= pick(mo_last);
                mo_cnt   <= 0;
            end
        end else if (!m_cyc[mo_owner]) begin
            mo_owner <= -1;
            mo_cnt   <= 0;
        end else if (m_stb[mo_owner] && !(s_ack || s_err || s_rty)) begin
            mo_cnt <= (mo_cnt + 1 == T) ? 0 : mo_cnt + 1;
        end else begin
            mo_cnt <= 0;
        end
    end

    task automatic compare_all();
        int k;
        logic cyc_k, stb_k, hit;
        logic [N-1:0] e_grant, bit_k;
        k = mo_owner;
        if (k < 0) begin
            cyc_k = 1'b0; stb_k = 1'b0; hit = 1'b0; e_grant = '0; bit_k = '0;
        end else begin
            cyc_k   = m_cyc[k];
            stb_k   = m_stb[k];
            // this strobed cycle is unanswered number mo_cnt+1
            hit     = cyc_k && stb_k && !(s_ack || s_err || s_rty) && (mo_cnt + 1 == T);
            e_grant = N'(1 << k);
            bit_k   = N'(1 << k);
        end
        chk("grant", 64'(grant_o), 64'(e_grant));
        chk("s_cyc", 64'(s_cyc_o), 64'(cyc_k));
        chk("s_stb", 64'(s_stb_o), 64'(cyc_k && stb_k && !hit));
        chk("s_adr", 64'(s_adr_o), cyc_k ? 64'(m_adr[k*AW +: AW]) : 64'd0);
        chk("s_dat", 64'(s_dat_o), cyc_k ? 64'(m_dat[k*DW +: DW]) : 64'd0);
        chk("s_sel", 64'(s_sel_o), cyc_k ? 64'(m_sel[k*4 +: 4]) : 64'd0);
        chk("s_we",  64'(s_we_o),  cyc_k ? 64'(m_we[k]) : 64'd0);
        chk("s_cti", 64'(s_cti_o), cyc_k ? 64'(m_cti[k*3 +: 3]) : 64'd0);
        chk("s_bte", 64'(s_bte_o), cyc_k ? 64'(m_bte[k*2 +: 2]) : 64'd0);
        chk("m_dat", 64'(m_dat_o), 64'(s_dat));
        chk("m_ack", 64'(m_ack_o), s_ack ? 64'(bit_k) : 64'd0);
        chk("m_err", 64'(m_err_o), (s_err || hit) ? 64'(bit_k) : 64'd0);
        chk("m_rty", 64'(m_rty_o), s_rty ? 64'(bit_k) : 64'd0);
        chk("grant_t0", 64'(grant_o0), 64'(e_grant));
        chk("s_stb_t0", 64'(s_stb_o0), 64'(cyc_k && stb_k));
        chk("m_err_t0", 64'(m_err_o0), s_err ? 64'(bit_k) : 64'd0);
    endtask

    always @(negedge clk) compare_all();

    task automatic wait_grant(input logic [N-1:0] g);
        int n = 0;
        while (grant_o !== g && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("grant_wait", 64'(grant_o), 64'(g));
    endtask

    task automatic idle_all();
        m_cyc = '0; m_stb = '0;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    int order[$];
    int ack_cyc[$];

    initial begin
        int ack_pending, dropped, cyc_no, errs;
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cti = '0; m_bte = '0;
        s_dat = '0;
        m_cyc = 3'b111; m_stb = 3'b111;
        s_ack = 1'b1; s_err = 1'b1; s_rty = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_ack", 64'(m_ack_o), 64'd0);
        chk("rst_err", 64'(m_err_o), 64'd0);
        chk("rst_rty", 64'(m_rty_o), 64'd0);
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_first_grant", 64'(grant_o), 64'b001);

        // round robin, single access per tenure
        ack_pending = -1; dropped = -1; cyc_no = 0;
        while (order.size() < 6 && cyc_no < 40) begin
            @(posedge clk); #1;
            cyc_no++;
            s_ack = 1'b0;
            if (dropped >= 0) begin
                m_cyc[dropped] = 1'b1; m_stb[dropped] = 1'b1; dropped = -1;
            end
            if (ack_pending >= 0) begin
                m_cyc[ack_pending] = 1'b0; m_stb[ack_pending] = 1'b0;
                dropped = ack_pending; ack_pending = -1;
            end else if (grant_o != '0) begin
                for (int i = 0; i < N; i++) if (grant_o[i]) ack_pending = i;
                order.push_back(ack_pending);
                ack_cyc.push_back(cyc_no);
                s_ack = 1'b1;
            end
        end
        chk("rr_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < order.size(); i++) chk("rr_order", 64'(order[i]), 64'(i % 3));
        for (int i = 1; i < ack_cyc.size(); i++) chk("rr_gap", 64'(ack_cyc[i] - ack_cyc[i-1]), 64'd3);
        idle_all();

        // burst lock
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cti[5:3] = 3'b010;
        wait_grant(3'b010);
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            m_cti[5:3] = (b == 7) ? 3'b111 : 3'b010;
            m_adr[63:32] = 32'h100 + 32'(b * 4);
            s_ack = 1'b1;
            #1;
            chk("burst_grant", 64'(grant_o), 64'b010);
            chk("burst_ack", 64'(m_ack_o), 64'b010);
            chk("burst_cti", 64'(s_cti_o), (b == 7) ? 64'b111 : 64'b010);
            @(posedge clk); #1;
        end
        s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        #1 chk("burst_release_hold", 64'(grant_o), 64'b010);
        @(posedge clk); #1;
        chk("burst_idle", 64'(grant_o), 64'b000);
        @(posedge clk); #1;
        chk("burst_next", 64'(grant_o), 64'b001);
        idle_all();

        // response routing
        m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        wait_grant(3'b100);
        s_dat = 32'hDEADBEEF; s_ack = 1'b1;
        #1;
        chk("route_ack", 64'(m_ack_o), 64'b100);
        chk("route_dat", 64'(m_dat_o), 64'hDEADBEEF);
        @(posedge clk); #1;
        s_ack = 1'b0; s_err = 1'b1;
        #1;
        chk("route_err", 64'(m_err_o), 64'b100);
        chk("route_err_ack", 64'(m_ack_o), 64'b000);
        idle_all();

        // watchdog: no slave response at all
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        wait_grant(3'b001);
        errs = 0;
        for (int n = 1; n <= 20; n++) begin
            #1;
            chk("wd_err", 64'(m_err_o[0]), 64'(n == T));
            chk("wd_stb", 64'(s_stb_o), 64'(n != T));
            chk("wd0_err", 64'(m_err_o0), 64'd0);
            chk("wd0_stb", 64'(s_stb_o0), 64'd1);
            errs += int'(m_err_o[0]);
            @(posedge clk); #1;
        end
        chk("wd_err_count", 64'(errs), 64'd1);
        chk("wd_grant_kept", 64'(grant_o), 64'b001);
        idle_all();

        // asynchronous reset in the middle of a burst
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cti[2:0] = 3'b010;
        wait_grant(3'b001);
        s_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk("arst_ack", 64'(m_ack_o), 64'd0);
        s_ack = 1'b0; m_cti = '0;
        m_cyc = 3'b111; m_stb = 3'b111;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_first_grant", 64'(grant_o), 64'b001);
        idle_all();

        // randomized traffic, checked every cycle by the model
        for (int c = 0; c < 2000; c++) begin
            int drop_r, resp_r;
            @(posedge clk); #1;
            drop_r = (c < 1000) ? 7 : 63;
            resp_r = (c < 1000) ? 3 : 15;
            for (int m = 0; m < N; m++) begin
                if (m_cyc[m]) begin
                    if ($urandom_range(drop_r) == 0) begin
                        m_cyc[m] = 1'b0; m_stb[m] = 1'b0;
                    end else begin
                        m_stb[m] = (c < 1000) ? 1'($urandom_range(1)) : ($urandom_range(7) != 0);
                    end
                end else if ($urandom_range(3) == 0) begin
                    m_cyc[m] = 1'b1; m_stb[m] = 1'($urandom_range(1));
                end
            end
            m_adr = {$urandom, $urandom, $urandom};
            m_dat = {$urandom, $urandom, $urandom};
            m_sel = 12'($urandom);
            m_we  = 3'($urandom);
            m_cti = 9'($urandom);
            m_bte = 6'($urandom);
            s_dat = $urandom;
            s_ack = ($urandom_range(resp_r) == 0);
            s_err = (c < 1000) ? ($urandom_range(resp_r) == 0) : 1'b0;
            s_rty = (c < 1000) ? ($urandom_range(resp_r) == 0) : 1'b0;
        end
        idle_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
